// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory response block.
// Holds the FSM state encoding, the memory operation encoding, the default
// geometry/latency constants and the alignment helper used at accept time.
package mem_pkg;

  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WR_HI  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_WR32 = 2'd1,
    OP_WR64 = 2'd2
  } op_e;

  // 64-bit stores need doubleword alignment, everything else word alignment.
  function automatic logic misaligned(input op_e op, input logic [2:0] lsb);
    logic m;
    if (op == OP_WR64) begin
      m = (lsb != 3'd0);
    end else begin
      m = (lsb[1:0] != 2'd0);
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 32-bit data RAM, synchronous write and synchronous read,
// no reset on the array or the read register.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  read data, registered, valid the cycle after addr_i is presented
module dmem_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage array and read register; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory access engine for the MEM pipeline stage.
// Accepts one load / 32-bit store / 64-bit store at a time, stalls the
// pipeline while the access is in flight and pulses Mem_valid on completion.
// Ports:
//   Clk, Rst_n                       clock, async active-low reset
//   MemRead, MemWrite, MemWrite64    requests (priority WR64 > WR32 > RD)
//   Adrs_MEM                         byte address (wraps modulo DEPTH words)
//   Rt_data_MEM, Rt_data64_MEM       store data
//   Read_data                        last load result, held between loads
//   Mem_valid                        one-cycle completion pulse
//   Mem_stall                        high while an access is in progress
//   Addr_err                         misalignment flag, pulses with Mem_valid
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemWrite64,
  input  logic [31:0] Adrs_MEM,
  input  logic [31:0] Rt_data_MEM,
  input  logic [63:0] Rt_data64_MEM,
  output logic [31:0] Read_data,
  output logic        Mem_valid,
  output logic        Mem_stall,
  output logic        Addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [63:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            stall_q, stall_d;
  logic            addr_err_q, addr_err_d;

  logic [AW-1:0]   in_idx_s;
  logic            ram_we_s;
  logic [AW-1:0]   ram_addr_s;
  logic [31:0]     ram_wdata_s;
  logic [31:0]     ram_rdata_s;
  logic            unused_addr_s;

  assign in_idx_s      = Adrs_MEM[AW+1:2];
  assign unused_addr_s = ^Adrs_MEM[31:AW+2];

  // In IDLE the RAM is addressed straight from the request so the read data
  // is already registered when the access executes, even for LATENCY=1.
  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Next-state, RAM control and next-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    stall_d     = 1'b0;
    addr_err_d  = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = idx_q;
    ram_wdata_s = data_q[31:0];

    case (state_q)
      S_IDLE: begin
        ram_addr_s = in_idx_s;
        if (MemWrite64 || MemWrite || MemRead) begin
          if (MemWrite64) begin
            op_d   = OP_WR64;
            data_d = Rt_data64_MEM;
          end else if (MemWrite) begin
            op_d   = OP_WR32;
            data_d = {32'h0000_0000, Rt_data_MEM};
          end else begin
            op_d   = OP_RD;
            data_d = data_q;
          end
          idx_d   = in_idx_s;
          err_d   = misaligned(op_d, Adrs_MEM[2:0]);
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
          stall_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (cnt_q == {CW{1'b0}}) begin
          // Execute edge: misaligned accesses complete without side effects.
          ram_we_s = (op_q != OP_RD) && !err_q;
          if (op_q == OP_RD) begin
            rdata_d = err_q ? 32'h0000_0000 : ram_rdata_s;
          end else begin
            rdata_d = rdata_q;
          end
          if (op_q == OP_WR64) begin
            state_d = S_WR_HI;
            stall_d = 1'b1;
          end else begin
            state_d    = S_DONE;
            valid_d    = 1'b1;
            addr_err_d = err_q;
          end
        end else begin
          cnt_d   = cnt_q - CW'(1);
          stall_d = 1'b1;
        end
      end

      S_WR_HI: begin
        ram_addr_s  = idx_q + AW'(1);
        ram_wdata_s = data_q[63:32];
        ram_we_s    = !err_q;
        state_d     = S_DONE;
        valid_d     = 1'b1;
        addr_err_d  = err_q;
      end

      S_DONE: begin
        // Requests are ignored here so a held request is not re-executed.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears outputs immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_RD;
      cnt_q      <= {CW{1'b0}};
      idx_q      <= {AW{1'b0}};
      data_q     <= 64'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign Read_data = rdata_q;
  assign Mem_valid = valid_q;
  assign Mem_stall = stall_q;
  assign Addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp (DEPTH=256, LATENCY=2) with a
// transaction-level reference model and a per-cycle output comparator.
module tb_data_mem_resp;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        Clk;
  logic        Rst_n;
  logic        MemRead, MemWrite, MemWrite64;
  logic [31:0] Adrs_MEM, Rt_data_MEM;
  logic [63:0] Rt_data64_MEM;
  logic [31:0] Read_data;
  logic        Mem_valid, Mem_stall, Addr_err;

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemWrite64    (MemWrite64),
    .Adrs_MEM      (Adrs_MEM),
    .Rt_data_MEM   (Rt_data_MEM),
    .Rt_data64_MEM (Rt_data64_MEM),
    .Read_data     (Read_data),
    .Mem_valid     (Mem_valid),
    .Mem_stall     (Mem_stall),
    .Addr_err      (Addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int valid_cyc = 0;
  int stall_run = 0;
  int last_stall_run = 0;
  bit chk_en = 1'b0;

  // Reference model state: expected outputs and word-indexed memory image.
  logic        exp_stall, exp_valid, exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] mem_m [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("stall", 64'(Mem_stall), 64'(exp_stall));
      check("valid", 64'(Mem_valid), 64'(exp_valid));
      check("addr_err", 64'(Addr_err), 64'(exp_err));
      check("read_data", 64'(Read_data), 64'(exp_rdata));
      if (Mem_stall) stall_run++;
      if (Mem_valid) begin
        valid_cyc = cyc;
        last_stall_run = stall_run;
        stall_run = 0;
      end
    end
  end

  task automatic clear_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; MemWrite64 = 1'b0;
  endtask

  // Issue one request from IDLE and advance the model through its whole life:
  // winner by priority, alignment rule, total latency LATENCY+1 (+1 for 64-bit).
  task automatic do_op(input logic rd, input logic wr, input logic w64,
                       input logic [31:0] a, input logic [31:0] d32,
                       input logic [63:0] d64, input bit hold);
    int op; bit err; int idx; int len;
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; MemWrite64 = w64;
    Adrs_MEM = a; Rt_data_MEM = d32; Rt_data64_MEM = d64;
    req_cyc = cyc;
    op  = w64 ? 2 : (wr ? 1 : 0);
    err = (op == 2) ? (a[2:0] != 3'd0) : (a[1:0] != 2'd0);
    idx = int'(a >> 2) % DEPTH;
    len = (op == 2) ? LATENCY + 2 : LATENCY + 1;
    for (int k = 1; k <= len; k++) begin
      @(posedge Clk); #1;
      if (k == 1 && !hold) clear_inputs();
      exp_stall = (k < len);
      exp_valid = (k == len);
      exp_err   = (k == len) && err;
      if (k == len) begin
        if (!err && op == 1) mem_m[idx] = d32;
        if (!err && op == 2) begin
          mem_m[idx] = d64[31:0];
          mem_m[(idx + 1) % DEPTH] = d64[63:32];
        end
        if (op == 0) exp_rdata = err ? 32'h0 : mem_m[idx];
      end
    end
    @(posedge Clk); #1;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    do_op(1'b1, 1'b0, 1'b0, a, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    do_op(1'b0, 1'b1, 1'b0, a, d, 64'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0;
    clear_inputs();
    Adrs_MEM = 32'h0; Rt_data_MEM = 32'h0; Rt_data64_MEM = 64'h0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_stall", 64'(Mem_stall), 64'd0);
    check("rst_valid", 64'(Mem_valid), 64'd0);
    check("rst_err", 64'(Addr_err), 64'd0);
    check("rst_rdata", 64'(Read_data), 64'd0);
    @(negedge Clk); Rst_n = 1'b1;
    #1 chk_en = 1'b1;

    // Basic store / load round trip with latency and stall length pins.
    store(32'h10, 32'hDEADBEEF);
    check("st_latency", 64'(valid_cyc - req_cyc), 64'd3);
    check("st_stall_len", 64'(last_stall_run), 64'd2);
    load(32'h10);
    check("ld_latency", 64'(valid_cyc - req_cyc), 64'd3);
    check("ld_stall_len", 64'(last_stall_run), 64'd2);
    check("ld_data", 64'(Read_data), 64'hDEADBEEF);

    // Misaligned accesses: flagged, zero data, memory untouched.
    store(32'h0C, 32'h0C0C0C0C);
    load(32'h13);
    check("misal_ld_data", 64'(Read_data), 64'h0);
    do_op(1'b0, 1'b0, 1'b1, 32'h0C, 32'h0, 64'hFFFFFFFF_EEEEEEEE, 1'b0);
    check("misal_w64_latency", 64'(valid_cyc - req_cyc), 64'd4);
    load(32'h0C);
    check("mem3_kept", 64'(Read_data), 64'h0C0C0C0C);
    load(32'h10);
    check("mem4_kept", 64'(Read_data), 64'hDEADBEEF);

    // 64-bit store at the top of memory.
    store(32'h3F8, 32'h0);
    store(32'h3FC, 32'h0);
    do_op(1'b0, 1'b0, 1'b1, 32'h7F8, 32'h0, 64'h11112222_33334444, 1'b0);
    check("w64_latency", 64'(valid_cyc - req_cyc), 64'd4);
    check("w64_stall_len", 64'(last_stall_run), 64'd3);
    load(32'h3F8);
    check("mem254", 64'(Read_data), 64'h33334444);
    load(32'h3FC);
    check("mem255", 64'(Read_data), 64'h11112222);

    // Read+write together: store wins, Read_data unchanged; address aliasing.
    do_op(1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 64'h0, 1'b0);
    check("rdwr_no_load", 64'(Read_data), 64'h11112222);
    load(32'h420);
    check("alias_ld", 64'(Read_data), 64'hA5A5A5A5);

    // All three requests: 64-bit store wins.
    do_op(1'b1, 1'b1, 1'b1, 32'h40, 32'h77777777, 64'h44444444_40404040, 1'b0);
    load(32'h44);
    check("prio_w64_hi", 64'(Read_data), 64'h44444444);

    // Held MemWrite: one execution per DONE/IDLE pass.
    do_op(1'b0, 1'b1, 1'b0, 32'h50, 32'h50505050, 64'h0, 1'b1);
    do_op(1'b0, 1'b1, 1'b0, 32'h50, 32'h51515151, 64'h0, 1'b0);
    check("hold_latency", 64'(valid_cyc - req_cyc), 64'd3);
    load(32'h50);
    check("hold_data", 64'(Read_data), 64'h51515151);

    // Reset during WR_HI: low word written, high word keeps old value.
    store(32'h60, 32'h60606060);
    store(32'h64, 32'h64646464);
    @(negedge Clk);
    MemWrite64 = 1'b1; Adrs_MEM = 32'h60; Rt_data64_MEM = 64'hBBBBCCCC_DDDDEEEE;
    @(posedge Clk); #1;
    clear_inputs();
    exp_stall = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    mem_m[24] = 32'hDDDDEEEE;
    check("wrhi_stall", 64'(Mem_stall), 64'd1);
    #2;
    chk_en = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("rst_wrhi_stall", 64'(Mem_stall), 64'd0);
    check("rst_wrhi_valid", 64'(Mem_valid), 64'd0);
    check("rst_wrhi_err", 64'(Addr_err), 64'd0);
    check("rst_wrhi_rdata", 64'(Read_data), 64'd0);
    exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge Clk);
    load(32'h60);
    check("rst_lo_written", 64'(Read_data), 64'hDDDDEEEE);
    load(32'h64);
    check("rst_hi_kept", 64'(Read_data), 64'h64646464);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
